// File: rtl/exec_unit_dtypes.sv
// Shared execution-unit datatypes: instruction-queue entry layout and queue sizing.
package exec_unit_dtypes;

    // Default number of entries in each ALPU instruction queue.
    localparam int IQUEUE_DEPTH = 4;

    // Width of the head-stall watchdog counter.
    localparam int IQUEUE_STALL_BITS = 8;

    // One dispatched instruction waiting for its operands.
    // op0m/op1m mark operands that must be fetched through the operand cache.
    typedef struct packed {
        logic [3:0] opcode;
        logic [4:0] opd;
        logic       op0m;
        logic [4:0] op0;
        logic       op1m;
        logic [4:0] op1;
    } type_iqueue_entry;

endpackage

// File: rtl/alpu_iqueue.sv
// Per-ALPU in-order instruction queue feeding the operand cache, with a
// head-stall watchdog that makes a deadlocked operand fetch visible.
module alpu_iqueue
    import exec_unit_dtypes::*;
#(
    parameter int DEPTH       = IQUEUE_DEPTH,
    parameter int STALL_LIMIT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     disp_valid_i,
    input  type_iqueue_entry         disp_entry_i,
    output logic                     disp_ready_o,
    output type_iqueue_entry         ireq_curr_instr,
    output logic                     ireq_valid_o,
    input  logic                     alpu_issue_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     stall_o
);

    localparam int IDX_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = IDX_BITS + 1;

    localparam logic [IDX_BITS-1:0]          PTR_ONE     = IDX_BITS'(1);
    localparam logic [CNT_BITS-1:0]          CNT_ONE     = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]          CNT_FULL    = CNT_BITS'(DEPTH);
    localparam logic [IQUEUE_STALL_BITS-1:0] STALL_MAX   = '1;
    localparam logic [IQUEUE_STALL_BITS-1:0] STALL_ONE   = IQUEUE_STALL_BITS'(1);
    localparam logic [IQUEUE_STALL_BITS-1:0] STALL_LIM_W = IQUEUE_STALL_BITS'(STALL_LIMIT);

    type_iqueue_entry               mem [DEPTH];
    logic [IDX_BITS-1:0]            rd_ptr;
    logic [IDX_BITS-1:0]            wr_ptr;
    logic [CNT_BITS-1:0]            count;
    logic [IQUEUE_STALL_BITS-1:0]   stall_cnt;
    logic [IQUEUE_STALL_BITS-1:0]   stall_cnt_next;
    logic                           stall_q;
    logic                           push;
    logic                           pop;

    // Outputs depend only on registered state, so no input reaches an output combinationally.
    assign disp_ready_o    = (count != CNT_FULL);
    assign ireq_valid_o    = (count != '0);
    assign ireq_curr_instr = ireq_valid_o ? mem[rd_ptr] : '0;
    assign count_o         = count;
    assign stall_o         = stall_q;

    // Flush wins over both handshakes; an issue against an empty queue is ignored.
    assign push = disp_valid_i & disp_ready_o & ~flush_i;
    assign pop  = alpu_issue_i & ireq_valid_o & ~flush_i;

    // Pointer and occupancy bookkeeping; count is kept apart from the pointers so full and empty never alias.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; slots are only read while counted as occupied.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale slots are masked by count, and skipping reset keeps it a plain register file.
        if (!reset && push) mem[wr_ptr] <= disp_entry_i;
    end

    // Watchdog next value: clear whenever the head is not waiting, else saturating increment.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned and infers a latch.
        stall_cnt_next = stall_cnt;
        if (flush_i || pop || !ireq_valid_o) begin
            stall_cnt_next = '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt_next = stall_cnt + STALL_ONE;
        end
    end

    // Watchdog counter and its registered threshold flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            stall_q   <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_next;
            stall_q   <= (stall_cnt_next >= STALL_LIM_W);
        end
    end

endmodule

// File: tb/tb_alpu_iqueue.sv
// Self-checking bench for alpu_iqueue: directed scenarios plus a randomized
// run, all compared against a queue-based behavioural model.
module tb_alpu_iqueue;
    import exec_unit_dtypes::*;

    localparam int DEPTH       = 4;
    localparam int STALL_LIMIT = 5;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 disp_valid_i = 1'b0;
    type_iqueue_entry     disp_entry_i = '0;
    logic                 disp_ready_o;
    type_iqueue_entry     ireq_curr_instr;
    logic                 ireq_valid_o;
    logic                 alpu_issue_i = 1'b0;
    logic                 flush_i = 1'b0;
    logic [CW-1:0]        count_o;
    logic                 stall_o;

    int checks = 0;
    int passes = 0;

    // Reference model: the queue contents and how long the head has waited.
    type_iqueue_entry mq[$];
    int               head_wait = 0;

    alpu_iqueue #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .disp_valid_i    (disp_valid_i),
        .disp_entry_i    (disp_entry_i),
        .disp_ready_o    (disp_ready_o),
        .ireq_curr_instr (ireq_curr_instr),
        .ireq_valid_o    (ireq_valid_o),
        .alpu_issue_i    (alpu_issue_i),
        .flush_i         (flush_i),
        .count_o         (count_o),
        .stall_o         (stall_o)
    );

    always #5 clk = ~clk;

    // The ALPU must never issue against an empty queue.
    always @(negedge clk) begin
        if (!reset && alpu_issue_i) begin
            checks++;
            if (ireq_valid_o !== 1'b1) $display("FAIL issue_on_empty: ireq_valid_o=%b required 1", ireq_valid_o);
            else passes++;
        end
    end

    function automatic type_iqueue_entry make_entry(input logic [3:0] tag);
        logic [31:0]      r;
        type_iqueue_entry e;
        r        = $urandom;
        e        = r[$bits(type_iqueue_entry)-1:0];
        e.opcode = tag;
        e.op0m   = 1'b1;
        e.op1m   = 1'b1;
        return e;
    endfunction

    // Drive one cycle of inputs, clock it, and advance the model by the same cycle.
    task automatic step(input logic v, input type_iqueue_entry e, input logic iss,
                        input logic fl, input logic rs);
        bit do_pop;
        bit do_push;
        disp_valid_i = v;
        disp_entry_i = e;
        alpu_issue_i = iss;
        flush_i      = fl;
        reset        = rs;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            mq.delete();
            head_wait = 0;
        end else begin
            do_pop  = iss && (mq.size() > 0);
            do_push = v && (mq.size() < DEPTH);
            if (do_pop || mq.size() == 0) head_wait = 0;
            else if (head_wait < 255)     head_wait++;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        disp_valid_i = 1'b0;
        alpu_issue_i = 1'b0;
        flush_i      = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, make_entry(4'h1), 1'b0, 1'b0, 1'b1);
        step(1'b1, make_entry(4'h2), 1'b0, 1'b0, 1'b1);
        checks++; if (count_o !== '0) $display("FAIL reset_count: got %0d want 0", count_o); else passes++;
        checks++; if (ireq_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", ireq_valid_o); else passes++;
        checks++; if (disp_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", disp_ready_o); else passes++;
        checks++; if (ireq_curr_instr !== '0) $display("FAIL reset_instr: got %h want 0", ireq_curr_instr); else passes++;
        checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall_o); else passes++;
    endtask

    // Fill with A..D then offer a fifth entry while full; return A..D for the drain.
    task automatic test_fill(output type_iqueue_entry abcd [4]);
        for (int i = 0; i < 4; i++) abcd[i] = make_entry(4'(4'hA + i));
        step(1'b1, abcd[0], 1'b0, 1'b0, 1'b0);
        checks++; if (ireq_curr_instr !== abcd[0]) $display("FAIL fill_head_a: got %h want %h", ireq_curr_instr, abcd[0]); else passes++;
        checks++; if (ireq_valid_o !== 1'b1) $display("FAIL fill_valid: got %b want 1", ireq_valid_o); else passes++;
        for (int i = 1; i < 4; i++) step(1'b1, abcd[i], 1'b0, 1'b0, 1'b0);
        checks++; if (disp_ready_o !== 1'b0) $display("FAIL full_ready: got %b want 0", disp_ready_o); else passes++;
        checks++; if (count_o !== CW'(4)) $display("FAIL full_count: got %0d want 4", count_o); else passes++;
        step(1'b1, make_entry(4'hE), 1'b0, 1'b0, 1'b0);
        checks++; if (count_o !== CW'(4)) $display("FAIL full_reject_count: got %0d want 4", count_o); else passes++;
        checks++; if (ireq_curr_instr !== abcd[0]) $display("FAIL full_reject_head: got %h want %h", ireq_curr_instr, abcd[0]); else passes++;
    endtask

    task automatic test_drain(input type_iqueue_entry abcd [4]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ireq_curr_instr !== abcd[i]) $display("FAIL drain_order_%0d: got %h want %h", i, ireq_curr_instr, abcd[i]);
            else passes++;
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        checks++; if (ireq_valid_o !== 1'b0) $display("FAIL drain_valid: got %b want 0", ireq_valid_o); else passes++;
        checks++;
        if (ireq_curr_instr.op0m !== 1'b0 || ireq_curr_instr.op1m !== 1'b0)
            $display("FAIL drain_opm: got op0m=%b op1m=%b want 0 0", ireq_curr_instr.op0m, ireq_curr_instr.op1m);
        else passes++;
        checks++; if (count_o !== '0) $display("FAIL drain_count: got %0d want 0", count_o); else passes++;
    endtask

    task automatic test_back_to_back();
        type_iqueue_entry seq [10];
        for (int i = 0; i < 10; i++) seq[i] = make_entry(4'(i));
        step(1'b1, seq[0], 1'b0, 1'b0, 1'b0);
        step(1'b1, seq[1], 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, seq[j+1], 1'b1, 1'b0, 1'b0);
            checks++;
            if (count_o !== CW'(2)) $display("FAIL b2b_count_%0d: got %0d want 2", j, count_o); else passes++;
            checks++;
            if (ireq_curr_instr !== seq[j]) $display("FAIL b2b_head_%0d: got %h want %h", j, ireq_curr_instr, seq[j]);
            else passes++;
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (ireq_curr_instr !== seq[9]) $display("FAIL b2b_tail: got %h want %h", ireq_curr_instr, seq[9]); else passes++;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, make_entry(4'h5), 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (stall_o !== (k >= STALL_LIMIT)) $display("FAIL stall_cycle_%0d: got %b want %b", k, stall_o, k >= STALL_LIMIT);
            else passes++;
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (stall_o !== 1'b0) $display("FAIL stall_clear_on_issue: got %b want 0", stall_o); else passes++;
        step(1'b1, make_entry(4'h6), 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 300; k++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0);
            if (k >= STALL_LIMIT) begin
                checks++;
                if (stall_o !== 1'b1) $display("FAIL stall_hold_%0d: got %b want 1", k, stall_o); else passes++;
            end
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (stall_o !== 1'b0) $display("FAIL stall_sat_clear: got %b want 0", stall_o); else passes++;
    endtask

    task automatic test_flush();
        type_iqueue_entry y;
        for (int i = 0; i < 3; i++) step(1'b1, make_entry(4'(i)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, make_entry(4'hF), 1'b1, 1'b1, 1'b0);
        checks++; if (count_o !== '0) $display("FAIL flush_count: got %0d want 0", count_o); else passes++;
        checks++; if (ireq_valid_o !== 1'b0) $display("FAIL flush_valid: got %b want 0", ireq_valid_o); else passes++;
        checks++; if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall_o); else passes++;
        y = make_entry(4'h7);
        step(1'b1, y, 1'b0, 1'b0, 1'b0);
        checks++; if (count_o !== CW'(1)) $display("FAIL flush_discard_count: got %0d want 1", count_o); else passes++;
        checks++; if (ireq_curr_instr !== y) $display("FAIL flush_discard_head: got %h want %h", ireq_curr_instr, y); else passes++;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        type_iqueue_entry e;
        step(1'b1, make_entry(4'h1), 1'b0, 1'b0, 1'b0);
        step(1'b1, make_entry(4'h2), 1'b0, 1'b0, 1'b0);
        step(1'b1, make_entry(4'h3), 1'b1, 1'b0, 1'b1);
        checks++; if (count_o !== '0) $display("FAIL midreset_count: got %0d want 0", count_o); else passes++;
        checks++; if (ireq_valid_o !== 1'b0) $display("FAIL midreset_valid: got %b want 0", ireq_valid_o); else passes++;
        checks++; if (ireq_curr_instr !== '0) $display("FAIL midreset_instr: got %h want 0", ireq_curr_instr); else passes++;
        checks++; if (disp_ready_o !== 1'b1) $display("FAIL midreset_ready: got %b want 1", disp_ready_o); else passes++;
        e = make_entry(4'hE);
        step(1'b1, e, 1'b0, 1'b0, 1'b0);
        checks++; if (ireq_curr_instr !== e) $display("FAIL midreset_head_e: got %h want %h", ireq_curr_instr, e); else passes++;
        checks++; if (count_o !== CW'(1)) $display("FAIL midreset_count_e: got %0d want 1", count_o); else passes++;
    endtask

    task automatic test_random();
        type_iqueue_entry exp_head;
        logic v, iss, fl, rs;
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(0, 99) < 60);
            iss = (mq.size() > 0) && ($urandom_range(0, 99) < 45);
            fl  = ($urandom_range(0, 99) < 3);
            rs  = ($urandom_range(0, 199) < 1);
            step(v, make_entry(4'($urandom_range(0, 15))), iss, fl, rs);
            exp_head = (mq.size() > 0) ? mq[0] : '0;
            checks++;
            if (count_o !== CW'(mq.size())) $display("FAIL rnd_count_%0d: got %0d want %0d", c, count_o, mq.size()); else passes++;
            checks++;
            if (ireq_valid_o !== (mq.size() != 0)) $display("FAIL rnd_valid_%0d: got %b want %b", c, ireq_valid_o, mq.size() != 0); else passes++;
            checks++;
            if (disp_ready_o !== (mq.size() != DEPTH)) $display("FAIL rnd_ready_%0d: got %b want %b", c, disp_ready_o, mq.size() != DEPTH); else passes++;
            checks++;
            if (ireq_curr_instr !== exp_head) $display("FAIL rnd_head_%0d: got %h want %h", c, ireq_curr_instr, exp_head); else passes++;
            checks++;
            if (stall_o !== (head_wait >= STALL_LIMIT)) $display("FAIL rnd_stall_%0d: got %b want %b", c, stall_o, head_wait >= STALL_LIMIT); else passes++;
        end
    endtask

    initial begin
        type_iqueue_entry abcd [4];
        test_reset();
        test_fill(abcd);
        test_drain(abcd);
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
